view_update_scheduler: RTL and testbench
========================================

// Module: view_update_scheduler
// PURPOSE
//  Sequences view_matrix_calculator once per video frame. On frame_start it launches a recalculation when the
//  camera pose changed or an update was forced. It captures the result into a shadow buffer and commits it
//  atomically at the next frame_start, so the transform/raster pipeline sees one consistent matrix per frame.
//  Sits between camera/input logic and the vertex transform stage.
// PARAMETERS
//  COORD_WIDTH     16    width of pose coordinates and matrix elements
//  ANGLE_BITS      8     MSBs of each angle that the calculator consumes; used for change detection
//  TIMEOUT_CYCLES  1024  max cycles in WAIT before abort
// PORTS
//  clk_in            in   1              system clock
//  rst_n_in          in   1              async reset, active-low
//  frame_start       in   1              1-cycle pulse at start of frame (vsync-derived)
//  force_update      in   1              1-cycle pulse; forces a recalculation at the next frame_start
//  x_in,y_in,z_in    in   COORD_WIDTH    live camera position (signed)
//  rot_angle,side_angle in COORD_WIDTH   live camera angles (signed)
//  calc_start        out  1              start pulse to calculator
//  calc_x,calc_y,calc_z,calc_rot,calc_side out COORD_WIDTH  pose snapshot driven to calculator
//  calc_done         in   1              calculator done pulse
//  calc_view_matrix  in   [3:0][3:0][COORD_WIDTH]  calculator result; valid while calc_done=1
//  calc_forward_vec  in   [2:0][COORD_WIDTH]       calculator forward vector; valid while calc_done=1
//  view_matrix       out  [3:0][3:0][COORD_WIDTH]  committed matrix for the current frame
//  forward_vec       out  [2:0][COORD_WIDTH]       committed forward vector
//  matrix_valid      out  1              high once the first matrix has been committed
//  busy              out  1              high in LAUNCH or WAIT
//  timeout_err       out  1              sticky; set on WAIT timeout, cleared by the next successful capture
//  overrun_cnt       out  8              saturating count of frames where the calculation was still in WAIT
// BEHAVIOUR
//  Reset: every output is 0. State is IDLE. Snapshot is 0. The force flag is set, so the first frame always launches.
//  States: IDLE, LAUNCH, WAIT, PENDING.
//  Launch condition: launch = force_flag | pose_changed.
//   pose_changed compares x/y/z in full width and the angles on their top ANGLE_BITS only, live pose vs snapshot.
//  IDLE: on frame_start with launch, register the snapshot from the live pose and clear force_flag. Go to LAUNCH.
//   On frame_start without launch, stay in IDLE.
//  LAUNCH: calc_start=1 for exactly this one cycle. Clear the timeout counter. Go to WAIT.
//   The calc_* snapshot is stable from LAUNCH until the next launch.
//  WAIT: the counter increments each cycle.
//   On calc_done, latch the result into the shadow buffer, clear timeout_err, and go to PENDING.
//   On calc_done and frame_start in the same cycle, commit straight to the outputs and go to IDLE.
//   No overrun is counted in that case.
//   On frame_start without calc_done, overrun_cnt++ (saturating at 255) and stay in WAIT.
//   When the counter reaches TIMEOUT_CYCLES-1, set timeout_err and go to IDLE. Outputs are kept and force_flag is set.
//  PENDING: on frame_start, copy shadow to view_matrix/forward_vec and set matrix_valid=1.
//   In that same cycle evaluate the launch condition: go to LAUNCH (and take a new snapshot) if true, otherwise IDLE.
//  force_update pulses set force_flag in any state. A pulse coinciding with a launch stays set for the following frame.
//  calc_done outside WAIT is ignored.
//  Committed outputs change only on an edge where frame_start=1.
//  Latency: frame_start at edge t gives calc_start high in cycle t+1. The result is committed at the first
//   frame_start after calc_done.
//  Async reset mid-operation: return to the reset state immediately. A calc_done pulse in flight afterwards is ignored.
// STRUCTURE
//  view_sched_pkg: state enum, mat4_t/vec3_t packed typedefs parameterised on COORD_WIDTH, and an OVERRUN_MAX constant.
//  Sub-module pose_change_detect (combinational compare of live pose vs snapshot, honouring ANGLE_BITS).
//  The timeout counter and the shadow/active registers are inline.
// TESTING
//  1 Reset, then frame_start with pose (0,0,0,0,0): calc_start pulses one cycle later. Stub done after 40 cycles.
//    Next frame_start gives matrix_valid=1 and view_matrix equal to the stub value.
//  2 Unchanged pose, or only rot_angle[7:0] changed (0x0012->0x0034): frame_start produces no calc_start.
//    rot_angle 0x0100->0x0200 produces a launch.
//  3 Stub never asserts done: after TIMEOUT_CYCLES in WAIT, timeout_err=1 and state is IDLE, with view_matrix unchanged.
//    The next frame_start relaunches, and a successful done clears timeout_err.
//  4 Two frame_starts arrive during WAIT: overrun_cnt=2 and view_matrix is unchanged.
//    calc_done coinciding with frame_start commits on that same edge.
//  5 force_update with a static pose: exactly one launch at the next frame_start.
//    Reset asserted in WAIT: all outputs are 0, and a later stray calc_done is ignored.

Source files
------------

// File: rtl/view_update_scheduler_pkg.sv
// Shared types and constants for the per-frame view matrix scheduler.
package view_sched_pkg;

  localparam int COORD_W = 16;
  localparam logic [7:0] OVERRUN_MAX = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT,
    ST_PENDING
  } sched_state_e;

  typedef logic [COORD_W-1:0]            coord_t;
  typedef logic [3:0][3:0][COORD_W-1:0]  mat4_t;
  typedef logic [2:0][COORD_W-1:0]       vec3_t;

endpackage

// File: rtl/view_update_scheduler_pose_change_detect.sv
// Compares the live camera pose against the last launched snapshot.
// Positions are compared in full width. Angles are compared only on the MSBs
// that the calculator actually consumes, so sub-resolution jitter is ignored.
module pose_change_detect #(
  parameter int COORD_WIDTH = 16,
  parameter int ANGLE_BITS  = 8
) (
  input  logic [COORD_WIDTH-1:0] live_x,
  input  logic [COORD_WIDTH-1:0] live_y,
  input  logic [COORD_WIDTH-1:0] live_z,
  input  logic [COORD_WIDTH-1:0] live_rot,
  input  logic [COORD_WIDTH-1:0] live_side,
  input  logic [COORD_WIDTH-1:0] snap_x,
  input  logic [COORD_WIDTH-1:0] snap_y,
  input  logic [COORD_WIDTH-1:0] snap_z,
  input  logic [COORD_WIDTH-1:0] snap_rot,
  input  logic [COORD_WIDTH-1:0] snap_side,
  output logic                   pose_changed
);

  // Flag any positional difference or any difference in the angle MSBs.
  always_comb begin
    pose_changed = (live_x != snap_x) || (live_y != snap_y) || (live_z != snap_z) ||
                   (live_rot[COORD_WIDTH-1 -: ANGLE_BITS]  != snap_rot[COORD_WIDTH-1 -: ANGLE_BITS]) ||
                   (live_side[COORD_WIDTH-1 -: ANGLE_BITS] != snap_side[COORD_WIDTH-1 -: ANGLE_BITS]);
  end

endmodule

// File: rtl/view_update_scheduler.sv
// Runs the view matrix calculator at most once per frame and double-buffers its
// result so the downstream pipeline sees one consistent matrix per frame.
module view_update_scheduler
  import view_sched_pkg::*;
#(
  parameter int COORD_WIDTH    = 16,
  parameter int ANGLE_BITS     = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                             clk_in,
  input  logic                             rst_n_in,
  input  logic                             frame_start,
  input  logic                             force_update,
  input  logic [COORD_WIDTH-1:0]           x_in,
  input  logic [COORD_WIDTH-1:0]           y_in,
  input  logic [COORD_WIDTH-1:0]           z_in,
  input  logic [COORD_WIDTH-1:0]           rot_angle,
  input  logic [COORD_WIDTH-1:0]           side_angle,
  output logic                             calc_start,
  output logic [COORD_WIDTH-1:0]           calc_x,
  output logic [COORD_WIDTH-1:0]           calc_y,
  output logic [COORD_WIDTH-1:0]           calc_z,
  output logic [COORD_WIDTH-1:0]           calc_rot,
  output logic [COORD_WIDTH-1:0]           calc_side,
  input  logic                             calc_done,
  input  logic [3:0][3:0][COORD_WIDTH-1:0] calc_view_matrix,
  input  logic [2:0][COORD_WIDTH-1:0]      calc_forward_vec,
  output logic [3:0][3:0][COORD_WIDTH-1:0] view_matrix,
  output logic [2:0][COORD_WIDTH-1:0]      forward_vec,
  output logic                             matrix_valid,
  output logic                             busy,
  output logic                             timeout_err,
  output logic [7:0]                       overrun_cnt
);

  localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  sched_state_e state_q, state_d;
  logic [COORD_WIDTH-1:0] snap_x_q, snap_y_q, snap_z_q, snap_rot_q, snap_side_q;
  logic [COORD_WIDTH-1:0] snap_x_d, snap_y_d, snap_z_d, snap_rot_d, snap_side_d;
  logic force_flag_q, force_flag_d;
  logic calc_start_q, calc_start_d;
  logic busy_q, busy_d;
  logic timeout_err_q, timeout_err_d;
  logic [TO_W-1:0] timeout_cnt_q, timeout_cnt_d;
  logic [7:0] overrun_cnt_q, overrun_cnt_d;
  logic [3:0][3:0][COORD_WIDTH-1:0] shadow_mat_q, shadow_mat_d, view_matrix_q, view_matrix_d;
  logic [2:0][COORD_WIDTH-1:0] shadow_fwd_q, shadow_fwd_d, forward_vec_q, forward_vec_d;
  logic matrix_valid_q, matrix_valid_d;
  logic pose_changed;
  logic launch;
  logic take_launch;
  logic set_force;

  pose_change_detect #(
    .COORD_WIDTH(COORD_WIDTH),
    .ANGLE_BITS (ANGLE_BITS)
  ) u_pose_change_detect (
    .live_x      (x_in),
    .live_y      (y_in),
    .live_z      (z_in),
    .live_rot    (rot_angle),
    .live_side   (side_angle),
    .snap_x      (snap_x_q),
    .snap_y      (snap_y_q),
    .snap_z      (snap_z_q),
    .snap_rot    (snap_rot_q),
    .snap_side   (snap_side_q),
    .pose_changed(pose_changed)
  );

  assign launch = force_flag_q | pose_changed;

  // Next-state, snapshot, timeout, overrun and buffer-commit logic.
  always_comb begin
    state_d        = state_q;
    snap_x_d       = snap_x_q;
    snap_y_d       = snap_y_q;
    snap_z_d       = snap_z_q;
    snap_rot_d     = snap_rot_q;
    snap_side_d    = snap_side_q;
    timeout_err_d  = timeout_err_q;
    timeout_cnt_d  = timeout_cnt_q;
    overrun_cnt_d  = overrun_cnt_q;
    shadow_mat_d   = shadow_mat_q;
    shadow_fwd_d   = shadow_fwd_q;
    view_matrix_d  = view_matrix_q;
    forward_vec_d  = forward_vec_q;
    matrix_valid_d = matrix_valid_q;
    take_launch    = 1'b0;
    set_force      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (frame_start && launch) begin
          take_launch = 1'b1;
          state_d     = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        timeout_cnt_d = '0;
        state_d       = ST_WAIT;
      end
      ST_WAIT: begin
        timeout_cnt_d = timeout_cnt_q + TO_W'(1);
        if (calc_done) begin
          shadow_mat_d  = calc_view_matrix;
          shadow_fwd_d  = calc_forward_vec;
          timeout_err_d = 1'b0;
          if (frame_start) begin
            view_matrix_d  = calc_view_matrix;
            forward_vec_d  = calc_forward_vec;
            matrix_valid_d = 1'b1;
            state_d        = ST_IDLE;
          end else begin
            state_d = ST_PENDING;
          end
        end else begin
          if (frame_start && (overrun_cnt_q != OVERRUN_MAX)) begin
            overrun_cnt_d = overrun_cnt_q + 8'd1;
          end
          if (timeout_cnt_q == TO_LAST) begin
            timeout_err_d = 1'b1;
            set_force     = 1'b1;
            state_d       = ST_IDLE;
          end
        end
      end
      ST_PENDING: begin
        if (frame_start) begin
          view_matrix_d  = shadow_mat_q;
          forward_vec_d  = shadow_fwd_q;
          matrix_valid_d = 1'b1;
          if (launch) begin
            take_launch = 1'b1;
            state_d     = ST_LAUNCH;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (take_launch) begin
      snap_x_d    = x_in;
      snap_y_d    = y_in;
      snap_z_d    = z_in;
      snap_rot_d  = rot_angle;
      snap_side_d = side_angle;
    end

    force_flag_d = (take_launch ? 1'b0 : force_flag_q) | force_update | set_force;
    calc_start_d = (state_d == ST_LAUNCH);
    busy_d       = (state_d == ST_LAUNCH) || (state_d == ST_WAIT);
  end

  // All scheduler state; the force flag starts set so the first frame launches.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q        <= ST_IDLE;
      snap_x_q       <= '0;
      snap_y_q       <= '0;
      snap_z_q       <= '0;
      snap_rot_q     <= '0;
      snap_side_q    <= '0;
      force_flag_q   <= 1'b1;
      calc_start_q   <= 1'b0;
      busy_q         <= 1'b0;
      timeout_err_q  <= 1'b0;
      timeout_cnt_q  <= '0;
      overrun_cnt_q  <= '0;
      shadow_mat_q   <= '0;
      shadow_fwd_q   <= '0;
      view_matrix_q  <= '0;
      forward_vec_q  <= '0;
      matrix_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      snap_x_q       <= snap_x_d;
      snap_y_q       <= snap_y_d;
      snap_z_q       <= snap_z_d;
      snap_rot_q     <= snap_rot_d;
      snap_side_q    <= snap_side_d;
      force_flag_q   <= force_flag_d;
      calc_start_q   <= calc_start_d;
      busy_q         <= busy_d;
      timeout_err_q  <= timeout_err_d;
      timeout_cnt_q  <= timeout_cnt_d;
      overrun_cnt_q  <= overrun_cnt_d;
      shadow_mat_q   <= shadow_mat_d;
      shadow_fwd_q   <= shadow_fwd_d;
      view_matrix_q  <= view_matrix_d;
      forward_vec_q  <= forward_vec_d;
      matrix_valid_q <= matrix_valid_d;
    end
  end

  assign calc_start   = calc_start_q;
  assign calc_x       = snap_x_q;
  assign calc_y       = snap_y_q;
  assign calc_z       = snap_z_q;
  assign calc_rot     = snap_rot_q;
  assign calc_side    = snap_side_q;
  assign view_matrix  = view_matrix_q;
  assign forward_vec  = forward_vec_q;
  assign matrix_valid = matrix_valid_q;
  assign busy         = busy_q;
  assign timeout_err  = timeout_err_q;
  assign overrun_cnt  = overrun_cnt_q;

endmodule

// File: tb/tb_view_update_scheduler.sv
// Directed bench for view_update_scheduler: drives frame/force/done pulses
// by hand and compares against hand-computed expectations.
module tb_view_update_scheduler;
   import view_sched_pkg::*;

   logic        clk;
   logic        rstN;
   logic        frameStart;
   logic        forceUpdate;
   logic [15:0] xIn, yIn, zIn, rotAngle, sideAngle;
   logic        calcStart;
   logic [15:0] calcX, calcY, calcZ, calcRot, calcSide;
   logic        calcDone;
   mat4_t       calcViewMatrix;
   vec3_t       calcForwardVec;
   mat4_t       viewMatrix;
   vec3_t       forwardVec;
   logic        matrixValid;
   logic        busy;
   logic        timeoutErr;
   logic [7:0]  overrunCnt;

   int checkCount = 0;
   int errorCount = 0;

   mat4_t matA, matB, matC, matD;
   vec3_t vecA, vecB, vecC, vecD;

   view_update_scheduler dut (
      .clk_in          (clk),
      .rst_n_in        (rstN),
      .frame_start     (frameStart),
      .force_update    (forceUpdate),
      .x_in            (xIn),
      .y_in            (yIn),
      .z_in            (zIn),
      .rot_angle       (rotAngle),
      .side_angle      (sideAngle),
      .calc_start      (calcStart),
      .calc_x          (calcX),
      .calc_y          (calcY),
      .calc_z          (calcZ),
      .calc_rot        (calcRot),
      .calc_side       (calcSide),
      .calc_done       (calcDone),
      .calc_view_matrix(calcViewMatrix),
      .calc_forward_vec(calcForwardVec),
      .view_matrix     (viewMatrix),
      .forward_vec     (forwardVec),
      .matrix_valid    (matrixValid),
      .busy            (busy),
      .timeout_err     (timeoutErr),
      .overrun_cnt     (overrunCnt)
   );

   // Free-running 10-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic mat4_t makeMat(input logic [15:0] base);
      mat4_t m;
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++)
            m[i][j] = base + 16'(i * 4 + j);
      return m;
   endfunction

   function automatic vec3_t makeVec(input logic [15:0] base);
      vec3_t v;
      for (int i = 0; i < 3; i++)
         v[i] = base + 16'(i);
      return v;
   endfunction

   task automatic checkOutput(input string tag, input logic [255:0] observed, input logic [255:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
      end
   endtask

   // Hold the given pulses across exactly one rising edge, then sample point is 1 unit after it.
   task automatic applyStimulus(input logic fs, input logic fu, input logic done);
      frameStart  = fs;
      forceUpdate = fu;
      calcDone    = done;
      @(posedge clk);
      #1;
      frameStart  = 1'b0;
      forceUpdate = 1'b0;
      calcDone    = 1'b0;
   endtask

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0);
   endtask

   // Directed scenario sequence.
   initial begin
      int cycles;
      matA = makeMat(16'h1000); vecA = makeVec(16'h1A00);
      matB = makeMat(16'h2000); vecB = makeVec(16'h2A00);
      matC = makeMat(16'h3000); vecC = makeVec(16'h3A00);
      matD = makeMat(16'h4000); vecD = makeVec(16'h4A00);
      rstN = 1'b0; frameStart = 1'b0; forceUpdate = 1'b0; calcDone = 1'b0;
      xIn = '0; yIn = '0; zIn = '0; rotAngle = '0; sideAngle = '0;
      calcViewMatrix = matA; calcForwardVec = vecA;

      #12;
      checkOutput("reset_view_matrix", 256'(viewMatrix), 256'd0);
      checkOutput("reset_matrix_valid", 256'(matrixValid), 256'd0);
      checkOutput("reset_busy", 256'(busy), 256'd0);
      checkOutput("reset_calc_start", 256'(calcStart), 256'd0);
      checkOutput("reset_overrun", 256'(overrunCnt), 256'd0);
      rstN = 1'b1;
      @(posedge clk); #1;

      // 1: first frame always launches; result commits at the next frame_start
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("t1_calc_start_high", 256'(calcStart), 256'd1);
      checkOutput("t1_busy", 256'(busy), 256'd1);
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("t1_calc_start_one_cycle", 256'(calcStart), 256'd0);
      idleCycles(38);
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("t1_pending_not_valid", 256'(matrixValid), 256'd0);
      checkOutput("t1_pending_busy", 256'(busy), 256'd0);
      checkOutput("t1_pending_view_zero", 256'(viewMatrix), 256'd0);
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("t1_matrix_valid", 256'(matrixValid), 256'd1);
      checkOutput("t1_view_matrix", 256'(viewMatrix), 256'(matA));
      checkOutput("t1_forward_vec", 256'(forwardVec), 256'(vecA));
      checkOutput("t1_no_relaunch", 256'(calcStart), 256'd0);

      // 2: angle LSB changes are ignored, MSB changes launch
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("t2_static_no_launch", 256'(calcStart), 256'd0);
      rotAngle = 16'h0012;
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("t2_lsb_0012_no_launch", 256'(calcStart), 256'd0);
      rotAngle = 16'h0034;
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("t2_lsb_0034_no_launch", 256'(calcStart), 256'd0);
      rotAngle = 16'h0100;
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("t2_msb_launch", 256'(calcStart), 256'd1);
      checkOutput("t2_calc_rot", 256'(calcRot), 256'h0100);
      calcViewMatrix = matB; calcForwardVec = vecB;
      idleCycles(3);
      applyStimulus(1'b0, 1'b0, 1'b1);
      rotAngle = 16'h0200;
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("t2_commit_b", 256'(viewMatrix), 256'(matB));
      checkOutput("t2_pending_relaunch", 256'(calcStart), 256'd1);
      checkOutput("t2_calc_rot_0200", 256'(calcRot), 256'h0200);

      // 3: calculator never answers; timeout after TIMEOUT_CYCLES in WAIT
      cycles = 0;
      while (busy && cycles < 2000) begin
         applyStimulus(1'b0, 1'b0, 1'b0);
         cycles++;
      end
      checkOutput("t3_timeout_cycles", 256'(cycles), 256'd1025);
      checkOutput("t3_timeout_err", 256'(timeoutErr), 256'd1);
      checkOutput("t3_idle", 256'(busy), 256'd0);
      checkOutput("t3_view_kept", 256'(viewMatrix), 256'(matB));
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("t3_forced_relaunch", 256'(calcStart), 256'd1);
      calcViewMatrix = matC; calcForwardVec = vecC;
      idleCycles(5);
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("t3_timeout_cleared", 256'(timeoutErr), 256'd0);
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("t3_commit_c", 256'(viewMatrix), 256'(matC));

      // 4: overruns during WAIT, then done coinciding with frame_start
      xIn = 16'h0005;
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("t4_launch", 256'(calcStart), 256'd1);
      applyStimulus(1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0);
      idleCycles(4);
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("t4_overrun_two", 256'(overrunCnt), 256'd2);
      checkOutput("t4_view_unchanged", 256'(viewMatrix), 256'(matC));
      calcViewMatrix = matD; calcForwardVec = vecD;
      applyStimulus(1'b1, 1'b0, 1'b1);
      checkOutput("t4_direct_commit", 256'(viewMatrix), 256'(matD));
      checkOutput("t4_direct_fwd", 256'(forwardVec), 256'(vecD));
      checkOutput("t4_overrun_kept", 256'(overrunCnt), 256'd2);
      checkOutput("t4_idle", 256'(busy), 256'd0);

      // 5: force with static pose launches once; reset during WAIT
      applyStimulus(1'b0, 1'b1, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("t5_force_launch", 256'(calcStart), 256'd1);
      calcViewMatrix = matA; calcForwardVec = vecA;
      applyStimulus(1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b1);
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("t5_commit_a", 256'(viewMatrix), 256'(matA));
      checkOutput("t5_only_one_launch", 256'(calcStart), 256'd0);
      applyStimulus(1'b0, 1'b1, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("t5_in_wait", 256'(busy), 256'd1);
      rstN = 1'b0;
      #1;
      checkOutput("t5_rst_view", 256'(viewMatrix), 256'd0);
      checkOutput("t5_rst_valid", 256'(matrixValid), 256'd0);
      checkOutput("t5_rst_busy", 256'(busy), 256'd0);
      checkOutput("t5_rst_overrun", 256'(overrunCnt), 256'd0);
      checkOutput("t5_rst_calc_x", 256'(calcX), 256'd0);
      #2;
      rstN = 1'b1;
      @(posedge clk); #1;
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("t5_stray_done_busy", 256'(busy), 256'd0);
      checkOutput("t5_stray_done_valid", 256'(matrixValid), 256'd0);
      checkOutput("t5_stray_done_view", 256'(viewMatrix), 256'd0);

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
